// File: rtl/huffman_bit_packer.sv
// Packs Huffman codes for gray symbols 1..6 MSB-first into bytes through a 16-bit accumulator.
// The code table is captured in IDLE and stays frozen for the rest of the frame.
module huffman_bit_packer #(
  parameter int ACC_W = 16,
  parameter int OUT_W = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             code_valid,
  input  logic [47:0]      HC,
  input  logic [47:0]      M,
  input  logic             sym_valid,
  input  logic [7:0]       sym_data,
  input  logic             sym_last,
  output logic             sym_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_byte,
  input  logic             out_ready,
  output logic             out_last,
  output logic             done,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int NSYM = 6;
  localparam int LW   = $clog2(OUT_W + 1);
  localparam int FW   = $clog2(ACC_W + 1);
  localparam logic [FW-1:0] FILL_BYTE = FW'(OUT_W);
  localparam logic [FW-1:0] FILL_MAX  = FW'(ACC_W);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [OUT_W-1:0] code_tab [NSYM];
  logic [LW-1:0]    len_tab  [NSYM];
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [FW-1:0]    fill, fill_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic [OUT_W-1:0] cur_code;
  logic [LW-1:0]    cur_len;
  logic             sym_acc, out_acc, sym_ok;

  assign sym_ready = (state == RUN) && (fill <= FILL_BYTE);
  assign out_valid = (fill >= FILL_BYTE) || ((state == FLUSH) && (fill != '0));
  assign out_byte  = acc[ACC_W-1 -: OUT_W];
  assign out_last  = (state == FLUSH) && out_valid && (fill <= FILL_BYTE);
  assign done      = (state == FLUSH) && (fill == '0);
  assign sym_acc   = sym_valid && sym_ready;
  assign out_acc   = out_valid && out_ready;

  // Out-of-range symbols and zero-length entries both resolve to length 0.
  always_comb begin
    cur_code = '0;
    cur_len  = '0;
    for (int i = 0; i < NSYM; i++) begin
      if (sym_data == 8'(i + 1)) begin
        cur_code = code_tab[i];
        cur_len  = len_tab[i];
      end
    end
  end

  assign sym_ok = (cur_len != '0);

  // The outgoing byte is shifted out first so a same-cycle append lands behind the remaining bits.
  always_comb begin
    acc_nxt   = acc;
    fill_nxt  = fill;
    err_nxt   = err_cnt;
    state_nxt = state;
    if (out_acc) begin
      acc_nxt  = acc << OUT_W;
      fill_nxt = (fill >= FILL_BYTE) ? (fill - FILL_BYTE) : '0;
    end
    if (sym_acc) begin
      if (sym_ok) begin
        acc_nxt  = acc_nxt | (ACC_W'(cur_code) << (FILL_MAX - fill_nxt - FW'(cur_len)));
        fill_nxt = fill_nxt + FW'(cur_len);
      end else if (err_cnt != '1) begin
        err_nxt = err_cnt + ERR_W'(1);
      end
    end
    case (state)
      IDLE:    if (code_valid) state_nxt = RUN;
      RUN:     if (sym_acc && sym_last) state_nxt = FLUSH;
      FLUSH:   if (fill == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      fill    <= '0;
      err_cnt <= '0;
      for (int i = 0; i < NSYM; i++) begin
        code_tab[i] <= '0;
        len_tab[i]  <= '0;
      end
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      fill    <= fill_nxt;
      err_cnt <= err_nxt;
      if (state == IDLE && code_valid) begin
        for (int i = 0; i < NSYM; i++) begin
          code_tab[i] <= HC[(NSYM-1-i)*OUT_W +: OUT_W] & M[(NSYM-1-i)*OUT_W +: OUT_W];
          len_tab[i]  <= LW'($countones(M[(NSYM-1-i)*OUT_W +: OUT_W]));
        end
      end
    end
  end

endmodule
